// File: rtl/instmem_loader.sv
// -----------------------------------------------------------------------------
// instmem_loader
//
// Byte-serial programmer for an 8-bit-wide, byte-addressed instruction memory.
// It accepts 32-bit instruction words over a valid/ready handshake. Each word is
// written as four little-endian byte writes to consecutive addresses, with the
// least significant byte at the lowest address. This matches how fetch
// assembles a word: {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   start       one-cycle load request, honoured only in IDLE
//   start_adr   load base address; the low two bits are forced to zero
//   abort       cancels the load at the next edge from any non-IDLE state
//   w_valid     w_data / w_last are valid
//   w_data      32-bit instruction word
//   w_last      marks the final word of the image
//   w_ready     loader accepts a word this cycle
//   mem_we      byte write strobe to the memory
//   mem_adr     byte address of the current write (0 when mem_we = 0)
//   mem_din     byte being written (0 when mem_we = 0)
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last byte of the final word
//   word_count  words fully written since the last accepted start
// -----------------------------------------------------------------------------
module instmem_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_adr,
    input  logic              abort,
    input  logic              w_valid,
    input  logic [31:0]       w_data,
    input  logic              w_last,
    output logic              w_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [7:0]        mem_din,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] word_adr;   // byte address of byte 0 of the current word
    logic [1:0]        idx;        // byte lane being presented during WRITE
    logic [31:0]       word_q;     // captured instruction word
    logic              last_q;     // captured w_last
    logic [1:0]        idx_nxt;

    assign idx_nxt = idx + 2'd1;

    // Every output is a register loaded with the value the *next* state must
    // present, so no input reaches an output without passing through a flop.
    always_ff @(posedge clk) begin
        // NOTE: all control and data state is cleared on reset, including the
        // captured word, so a reset mid-load leaves nothing stale to replay.
        if (!rst_n) begin
            state      <= IDLE;
            word_adr   <= '0;
            idx        <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
            w_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_din    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort && state != IDLE) begin
            // The byte presented in this cycle is written by the memory at
            // this same edge; everything after it is cancelled.
            state   <= IDLE;
            w_ready <= 1'b0;
            mem_we  <= 1'b0;
            mem_adr <= '0;
            mem_din <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values regardless of statement order.
            unique case (state)
                IDLE: begin
                    if (start) begin
                        word_adr   <= {start_adr[ADDR_W-1:2], 2'b00};
                        word_count <= '0;
                        state      <= ARMED;
                        busy       <= 1'b1;
                        w_ready    <= 1'b1;
                    end
                end

                ARMED: begin
                    if (w_valid) begin
                        word_q  <= w_data;
                        last_q  <= w_last;
                        idx     <= 2'd0;
                        state   <= WRITE;
                        w_ready <= 1'b0;
                        mem_we  <= 1'b1;
                        mem_adr <= word_adr;
                        mem_din <= w_data[7:0];
                    end
                end

                WRITE: begin
                    if (idx == 2'd3) begin
                        word_adr   <= word_adr + ADDR_W'(4);
                        word_count <= word_count + (ADDR_W-1)'(1);
                        idx        <= 2'd0;
                        mem_we     <= 1'b0;
                        mem_adr    <= '0;
                        mem_din    <= '0;
                        if (last_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ARMED;
                            w_ready <= 1'b1;
                        end
                    end else begin
                        idx     <= idx_nxt;
                        mem_adr <= word_adr + ADDR_W'(idx_nxt);
                        mem_din <= word_q[{idx_nxt, 3'b000} +: 8];
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instmem_loader.sv
// -----------------------------------------------------------------------------
// tb_instmem_loader
//
// Directed bench for instmem_loader. The stimulus thread pushes each expected
// byte write (cycle, address, data) and each expected done pulse into queues;
// an independent monitor pops and compares whenever the DUT strobes mem_we or
// done. Any write or done pulse with no matching expectation is an error.
// -----------------------------------------------------------------------------
module tb_instmem_loader;

    localparam int ADDR_W = 16;

    typedef struct {
        int          cyc;
        logic [15:0] adr;
        logic [7:0]  din;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_adr;
    logic              abort;
    logic              w_valid;
    logic [31:0]       w_data;
    logic              w_last;
    logic              w_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [7:0]        mem_din;
    logic              busy;
    logic              done;
    logic [ADDR_W-2:0] word_count;

    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    wr_t exp_q[$];
    int  done_q[$];

    instmem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_adr  (start_adr),
        .abort      (abort),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_last     (w_last),
        .w_ready    (w_ready),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_din    (mem_din),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        vectors     = vectors + 1;
        miscompares = miscompares + 1;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: compare every byte write and every done pulse with the queues.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                unexpected("unexpected_write", {mem_adr, mem_din});
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_cycle", cyc, e.cyc);
                check("write_adr", mem_adr, e.adr);
                check("write_din", mem_din, e.din);
                check("ready_low_in_write", w_ready, 1'b0);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                unexpected("unexpected_done", done);
            end else begin
                int dc;
                dc = done_q.pop_front();
                check("done_cycle", cyc, dc);
            end
        end
    end

    // Called one step after a rising edge; returns the cycle in which w_ready
    // was seen high (the handshake happens at the following edge).
    task automatic wait_ready(output int hs);
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_ready) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) unexpected("ready_timeout", 0);
    endtask

    task automatic do_start(input logic [15:0] adr);
        start     = 1'b1;
        start_adr = adr;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy_ready", {busy, w_ready}, 2'b11);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last,
                             input logic [15:0] adr, output int hs);
        w_valid = 1'b1;
        w_data  = d;
        w_last  = last;
        wait_ready(hs);
        for (int k = 0; k < 4; k++) begin
            wr_t e;
            e.cyc = hs + 1 + k;
            e.adr = adr + 16'(k);
            e.din = d[8*k +: 8];
            exp_q.push_back(e);
        end
        if (last) done_q.push_back(hs + 5);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input logic [14:0] exp_count);
        w_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("word_count", word_count, exp_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, hs1, hs2;

        // Reset held for two edges with start and w_valid asserted.
        rst_n     = 1'b0;
        start     = 1'b1;
        start_adr = 16'h1234;
        abort     = 1'b0;
        w_valid   = 1'b1;
        w_data    = 32'hFFFF_FFFF;
        w_last    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {w_ready, mem_we, mem_adr, mem_din, busy, done, word_count}, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        start   = 1'b0;
        w_valid = 1'b0;
        @(negedge clk);
        check("post_reset_outputs",
              {w_ready, mem_we, mem_adr, mem_din, busy, done, word_count}, 0);
        @(posedge clk);
        #1;

        // Single word at 0x0010.
        do_start(16'h0010);
        send_word(32'h2402_0007, 1'b1, 16'h0010, hs0);
        wait_idle(15'd1);

        // Streaming from an unaligned base: 0x0013 rounds down to 0x0010.
        do_start(16'h0013);
        send_word(32'h0302_0100, 1'b0, 16'h0010, hs0);
        send_word(32'h0706_0504, 1'b0, 16'h0014, hs1);
        send_word(32'h0B0A_0908, 1'b1, 16'h0018, hs2);
        check("stream_gap_1", hs1 - hs0, 5);
        check("stream_gap_2", hs2 - hs1, 5);
        wait_idle(15'd3);

        // Address wrap across 0xFFFF.
        do_start(16'hFFFC);
        send_word(32'h1122_3344, 1'b0, 16'hFFFC, hs0);
        send_word(32'h5566_7788, 1'b1, 16'h0000, hs1);
        wait_idle(15'd2);

        // Stall in ARMED with an ignored start, then another start mid-write.
        do_start(16'h0040);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_state", {mem_we, busy, w_ready, mem_adr, mem_din},
                  {1'b0, 1'b1, 1'b1, 16'h0000, 8'h00});
            if (i == 3) begin
                start     = 1'b1;
                start_adr = 16'h0100;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        send_word(32'hAABB_CCDD, 1'b0, 16'h0040, hs0);
        start     = 1'b1;
        start_adr = 16'h0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_word(32'h0102_0304, 1'b1, 16'h0044, hs1);
        wait_idle(15'd2);

        // Abort during the idx=2 write of the first word.
        do_start(16'h0080);
        w_valid = 1'b1;
        w_data  = 32'h0C0B_0A09;
        w_last  = 1'b0;
        wait_ready(hs0);
        for (int k = 0; k < 3; k++) begin
            wr_t e;
            e.cyc = hs0 + 1 + k;
            e.adr = 16'h0080 + 16'(k);
            e.din = w_data[8*k +: 8];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_outputs", {mem_we, busy, w_ready, done}, 4'b0000);
        check("abort_word_count", word_count, 0);
        repeat (6) @(posedge clk);
        #1;

        // A fresh load after the abort.
        do_start(16'h0200);
        send_word(32'hDEAD_BEEF, 1'b1, 16'h0200, hs0);
        wait_idle(15'd1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_writes", exp_q.size(), 0);
        check("pending_done", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instmem_loader.md
# instmem_loader

Byte-serial programmer for the 8-bit-wide, byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready handshake and writes each word as four little-endian byte writes to consecutive addresses, least significant byte at the lowest address. This matches how the instruction-fetch side assembles a word: {mem[a+3], mem[a+2], mem[a+1], mem[a]}. The loader sits between the testbench or boot source and the memory's write port, and fills program images before fetch starts.

## Interface
Parameters:
- ADDR_W, 16, byte-address width of the target memory; addresses wrap mod 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- start_adr  input  ADDR_W  load base address, sampled with start; bits [1:0] are forced to 0.
- abort  input  1  cancels the load at the next edge from any non-IDLE state.
- w_valid  input  1  w_data/w_last are valid.
- w_data  input  32  instruction word.
- w_last  input  1  marks the final word of the image.
- w_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  byte write strobe to the memory.
- mem_adr  output  ADDR_W  byte address of the current write.
- mem_din  output  8  byte being written.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last byte of the w_last word is written.
- word_count  output  ADDR_W-1  words fully written since the last start.

## Operation
- State machine: IDLE, ARMED, WRITE, DONE.
- **IDLE**
  - start=1: word_adr <= {start_adr[ADDR_W-1:2], 2'b00}, word_count <= 0, go to ARMED.
  - Any other input is ignored.
- **ARMED**
  - w_ready=1.
  - On w_valid & w_ready: capture w_data and w_last, idx <= 0, go to WRITE.
  - While w_valid=0 the loader stays in ARMED and issues no writes.
- **WRITE**, lasts 4 cycles with idx = 0, 1, 2, 3:
  - mem_we=1.
  - mem_adr = word_adr + idx, modulo 2^ADDR_W.
  - mem_din = captured word[8*idx+7 : 8*idx].
  - After idx=3: word_adr <= word_adr + 4 (wraps), word_count <= word_count + 1 (wraps). Go to DONE if the captured last flag is set, otherwise go to ARMED.
- **DONE**: done=1 for one cycle, then go to IDLE. word_count holds its value until the next accepted start.
- **abort**
  - Takes priority over all other transitions; the next state is IDLE.
  - A byte write in the abort cycle still completes. No further writes occur and done is not pulsed.
  - word_count is unchanged.
- start outside IDLE is ignored and does not re-base the address.
- w_ready is 0 in IDLE, WRITE and DONE. Words offered there are not consumed.
- mem_adr and mem_din are 0 whenever mem_we=0.

## Timing
- Reset (rst_n=0 at an edge) puts the block in IDLE with these values:
  - w_ready=0, mem_we=0, mem_adr=0, mem_din=0, busy=0, done=0, word_count=0.
  - word_adr=0, idx=0, and the captured word and flag cleared.
  - Reset applied mid-load takes effect at that edge; an in-progress word is abandoned.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- start accepted at edge N: busy=1 and w_ready=1 from cycle N+1.
- Handshake at edge M: byte writes occur in cycles M+1 to M+4. The next ARMED (w_ready=1) cycle is M+5.
- Throughput: one word per 5 cycles with w_valid held high.
- done is high in cycle M+5 for a last word. busy falls in M+6.
- Address wrap: a word at 0xFFFC (ADDR_W=16) is followed by a word at 0x0000. No error is flagged.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 and w_valid=1. Required: all outputs 0, no mem_we, and busy=0 on the first cycle after release.
- Single word: start with start_adr=0x0010, then w_data=0x24020007, w_last=1. Required: writes (0x10,0x07), (0x11,0x00), (0x12,0x02), (0x13,0x24) on 4 consecutive cycles, then done for exactly one cycle and word_count=1.
- Streaming with alignment: start_adr=0x0013, three words with w_valid held high. Required:
  - Writes to 0x10 through 0x1B in order.
  - w_ready high for exactly one cycle in every 5.
  - word_count=3, and done in the cycle after the write to 0x1B.
- Wrap: start_adr=0xFFFC, two words 0x11223344 then 0x55667788 (last). Required: bytes 44,33,22,11 written at 0xFFFC through 0xFFFF, then 88,77,66,55 at 0x0000 through 0x0003.
- Stall and ignored start:
  - w_valid=0 for 7 cycles in ARMED: required no mem_we, busy=1, w_ready=1 throughout.
  - start pulse with start_adr=0x0100 mid-load: required addresses continue the original sequence.
- Abort: assert abort in the idx=2 write cycle of the first word. Required:
  - That byte is written.
  - mem_we=0 from the next cycle, busy=0, done never pulses, word_count=0.
  - A following start works normally.
